// File: rtl/tdm_pkg.sv
// Shared constants, state encoding and helpers for the TDM frame scheduler.
package tdm_pkg;
    localparam int WIDTH = 8;
    localparam int NUM_CH = 3;
    localparam int FRAME_LEN = NUM_CH * WIDTH;
    localparam logic [WIDTH-1:0] IDLE_BYTE = 8'h00;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Up to three underruns can land on one load edge; clamp at 255.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction
endpackage

// File: rtl/tdm_frame_scheduler_if.sv
// Requester handshakes, per-channel slot outputs and status of the TDM scheduler.
interface tdm_frame_scheduler_if #(parameter int WIDTH = tdm_pkg::WIDTH);
    logic             enable;
    logic [2:0]       ch_mask;
    logic [WIDTH-1:0] ch1_in, ch2_in, ch3_in;
    logic             ch1_valid, ch2_valid, ch3_valid;
    logic             ch1_ready, ch2_ready, ch3_ready;
    logic [WIDTH-1:0] channel1, channel2, channel3;
    logic             frame_start;
    logic             busy;
    logic [7:0]       underrun_cnt;

    modport master (
        output enable, ch_mask, ch1_in, ch2_in, ch3_in, ch1_valid, ch2_valid, ch3_valid,
        input  ch1_ready, ch2_ready, ch3_ready, channel1, channel2, channel3,
        input  frame_start, busy, underrun_cnt
    );

    modport slave (
        input  enable, ch_mask, ch1_in, ch2_in, ch3_in, ch1_valid, ch2_valid, ch3_valid,
        output ch1_ready, ch2_ready, ch3_ready, channel1, channel2, channel3,
        output frame_start, busy, underrun_cnt
    );
endinterface

// File: rtl/tdm_slot_reg.sv
// One channel slot: ready generation, capture or idle-fill of the slot byte, underrun flag.
module tdm_slot_reg #(
    parameter int           W    = tdm_pkg::WIDTH,
    parameter logic [W-1:0] FILL = tdm_pkg::IDLE_BYTE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_pend,
    input  logic         frame_stop,
    input  logic         mask_bit,
    input  logic         valid,
    input  logic [W-1:0] data_in,
    output logic         ready,
    output logic [W-1:0] data_out,
    output logic         underrun
);
    import tdm_pkg::*;

    assign ready    = mask_bit & load_pend;
    assign underrun = ready & ~valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= FILL;
        end else if (load_pend) begin
            data_out <= (ready && valid) ? data_in : FILL;
        end else if (frame_stop) begin
            data_out <= FILL;
        end
    end
endmodule

// File: rtl/tdm_frame_scheduler.sv
// Three-channel TDM frame scheduler: frame FSM, bit counter, frame_start and underrun counter.
//  state  | meaning
//  S_IDLE | no frame running; slots hold IDLE_BYTE, loads when enable is high
//  S_RUN  | frame in progress; bit_cnt walks 0..FRAME_LEN-1
module tdm_frame_scheduler #(
    parameter int               WIDTH     = tdm_pkg::WIDTH,
    parameter logic [WIDTH-1:0] IDLE_BYTE = tdm_pkg::IDLE_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    tdm_frame_scheduler_if.slave  bus
);
    import tdm_pkg::*;

    localparam int FLEN = NUM_CH * WIDTH;
    localparam int CW   = $clog2(FLEN);
    localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic          frame_start_q;
    logic [7:0]    ur_cnt;
    logic          at_last, load_pend, frame_stop;
    logic [2:0]    ur_flag;
    logic [1:0]    ur_add;

    assign at_last    = (state == S_RUN) && (bit_cnt == LAST);
    // Gated by rst so no ready leaks out while held in reset with enable high.
    assign load_pend  = !rst && bus.enable && ((state == S_IDLE) || at_last);
    assign frame_stop = at_last && !bus.enable;
    assign ur_add     = {1'b0, ur_flag[0]} + {1'b0, ur_flag[1]} + {1'b0, ur_flag[2]};

    tdm_slot_reg #(.W(WIDTH), .FILL(IDLE_BYTE)) u_slot1 (
        .clk(clk), .rst(rst), .load_pend(load_pend), .frame_stop(frame_stop),
        .mask_bit(bus.ch_mask[0]), .valid(bus.ch1_valid), .data_in(bus.ch1_in),
        .ready(bus.ch1_ready), .data_out(bus.channel1), .underrun(ur_flag[0])
    );

    tdm_slot_reg #(.W(WIDTH), .FILL(IDLE_BYTE)) u_slot2 (
        .clk(clk), .rst(rst), .load_pend(load_pend), .frame_stop(frame_stop),
        .mask_bit(bus.ch_mask[1]), .valid(bus.ch2_valid), .data_in(bus.ch2_in),
        .ready(bus.ch2_ready), .data_out(bus.channel2), .underrun(ur_flag[1])
    );

    tdm_slot_reg #(.W(WIDTH), .FILL(IDLE_BYTE)) u_slot3 (
        .clk(clk), .rst(rst), .load_pend(load_pend), .frame_stop(frame_stop),
        .mask_bit(bus.ch_mask[2]), .valid(bus.ch3_valid), .data_in(bus.ch3_in),
        .ready(bus.ch3_ready), .data_out(bus.channel3), .underrun(ur_flag[2])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            frame_start_q <= 1'b0;
            ur_cnt        <= 8'd0;
        end else begin
            frame_start_q <= load_pend;
            ur_cnt        <= sat_add(ur_cnt, ur_add);
            if (load_pend) begin
                state   <= S_RUN;
                bit_cnt <= '0;
            end else if (frame_stop) begin
                state   <= S_IDLE;
                bit_cnt <= '0;
            end else if (state == S_RUN) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign bus.frame_start  = frame_start_q;
    assign bus.busy         = (state == S_RUN);
    assign bus.underrun_cnt = ur_cnt;
endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// Self-checking bench for tdm_frame_scheduler: frame vector table plus enable-drop, reset and saturation sequences.
module tb_tdm_frame_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_frame_scheduler_if bus ();
    tdm_frame_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0] mask;
        logic [2:0] valid;
        logic [7:0] d1, d2, d3;
        logic [2:0] exp_ready;
        logic [7:0] e1, e2, e3;
        logic [7:0] exp_ur;
    } vec_t;

    typedef struct {
        logic [7:0] c1, c2, c3;
        logic [7:0] ur;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    exp_t last_exp;
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [2:0] rdy();
        return {bus.ch3_ready, bus.ch2_ready, bus.ch1_ready};
    endfunction

    task automatic drive(input logic [2:0] mask, input logic [2:0] valid,
                         input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
        bus.ch_mask   = mask;
        bus.ch1_valid = valid[0];
        bus.ch2_valid = valid[1];
        bus.ch3_valid = valid[2];
        bus.ch1_in    = d1;
        bus.ch2_in    = d2;
        bus.ch3_in    = d3;
    endtask

    task automatic push_exp(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                            input logic [7:0] ur);
        exp_t e;
        e.c1 = c1; e.c2 = c2; e.c3 = c3; e.ur = ur;
        sb.push_back(e);
    endtask

    // Called one step after a load edge.
    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            last_exp = e;
            check({tag, "_frame_start"}, 32'(bus.frame_start), 32'd1);
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_channel1"}, 32'(bus.channel1), 32'(e.c1));
            check({tag, "_channel2"}, 32'(bus.channel2), 32'(e.c2));
            check({tag, "_channel3"}, 32'(bus.channel3), 32'(e.c3));
            check({tag, "_underrun"}, 32'(bus.underrun_cnt), 32'(e.ur));
        end
    endtask

    // Advance n clocks inside a frame, recording any stray frame_start.
    task automatic span(input int n, output logic saw_fs);
        saw_fs = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (bus.frame_start) saw_fs = 1'b1;
        end
    endtask

    initial begin
        logic saw;

        vecs[0] = '{3'b111, 3'b111, 8'hAA, 8'hCC, 8'hF0, 3'b111, 8'hAA, 8'hCC, 8'hF0, 8'd0};
        vecs[1] = '{3'b111, 3'b101, 8'h11, 8'h22, 8'h33, 3'b111, 8'h11, 8'h00, 8'h33, 8'd1};
        vecs[2] = '{3'b101, 3'b111, 8'h44, 8'h55, 8'h66, 3'b101, 8'h44, 8'h00, 8'h66, 8'd1};
        vecs[3] = '{3'b000, 3'b000, 8'h77, 8'h88, 8'h99, 3'b000, 8'h00, 8'h00, 8'h00, 8'd1};
        vecs[4] = '{3'b111, 3'b000, 8'h77, 8'h88, 8'h99, 3'b111, 8'h00, 8'h00, 8'h00, 8'd4};
        vecs[5] = '{3'b011, 3'b010, 8'h12, 8'h34, 8'h56, 3'b011, 8'h00, 8'h34, 8'h00, 8'd5};
        vecs[6] = '{3'b110, 3'b110, 8'h9A, 8'hBC, 8'hDE, 3'b110, 8'h00, 8'hBC, 8'hDE, 8'd5};

        // Reset state, with enable and mask high to show ready stays low in reset.
        rst = 1'b1;
        bus.enable = 1'b1;
        drive(3'b111, 3'b111, 8'h5A, 8'h5A, 8'h5A);
        #3;
        check("rst_ready", 32'(rdy()), 32'd0);
        check("rst_channel1", 32'(bus.channel1), 32'h00);
        check("rst_channel2", 32'(bus.channel2), 32'h00);
        check("rst_channel3", 32'(bus.channel3), 32'h00);
        check("rst_underrun", 32'(bus.underrun_cnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_start", 32'(bus.frame_start), 32'd0);
        bus.enable = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Back-to-back frames from the vector table.
        bus.enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].mask, vecs[i].valid, vecs[i].d1, vecs[i].d2, vecs[i].d3);
            if (i > 0) begin
                span(23, saw);
                check($sformatf("v%0d_no_midframe_start", i), 32'(saw), 32'd0);
                check($sformatf("v%0d_hold_channel1", i), 32'(bus.channel1), 32'(last_exp.c1));
                check($sformatf("v%0d_hold_channel2", i), 32'(bus.channel2), 32'(last_exp.c2));
                check($sformatf("v%0d_hold_channel3", i), 32'(bus.channel3), 32'(last_exp.c3));
            end
            #1;
            check($sformatf("v%0d_ready", i), 32'(rdy()), 32'(vecs[i].exp_ready));
            push_exp(vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].exp_ur);
            tick(1);
            pop_check($sformatf("v%0d", i));
        end

        // Enable dropped mid-frame: frame completes, then IDLE with idle fill.
        tick(10);
        bus.enable = 1'b0;
        drive(3'b111, 3'b111, 8'h61, 8'h62, 8'h63);
        tick(13);
        #1;
        check("drop_busy_last_bit", 32'(bus.busy), 32'd1);
        check("drop_ready_last_bit", 32'(rdy()), 32'd0);
        tick(1);
        check("drop_busy", 32'(bus.busy), 32'd0);
        check("drop_frame_start", 32'(bus.frame_start), 32'd0);
        check("drop_channel1", 32'(bus.channel1), 32'h00);
        check("drop_channel2", 32'(bus.channel2), 32'h00);
        check("drop_channel3", 32'(bus.channel3), 32'h00);
        check("drop_underrun", 32'(bus.underrun_cnt), 32'd5);
        tick(3);
        check("drop_idle_ready", 32'(rdy()), 32'd0);
        check("drop_idle_busy", 32'(bus.busy), 32'd0);

        // Reset at bit_cnt 12 clears everything without a clock edge.
        bus.enable = 1'b1;
        drive(3'b111, 3'b111, 8'hA1, 8'hB2, 8'hC3);
        #1;
        check("rs_ready", 32'(rdy()), 32'b111);
        push_exp(8'hA1, 8'hB2, 8'hC3, 8'd5);
        tick(1);
        pop_check("rs_load");
        tick(12);
        #1;
        rst = 1'b1;
        #1;
        check("rs_async_channel1", 32'(bus.channel1), 32'h00);
        check("rs_async_channel2", 32'(bus.channel2), 32'h00);
        check("rs_async_channel3", 32'(bus.channel3), 32'h00);
        check("rs_async_underrun", 32'(bus.underrun_cnt), 32'd0);
        check("rs_async_busy", 32'(bus.busy), 32'd0);
        check("rs_async_ready", 32'(rdy()), 32'd0);
        drive(3'b111, 3'b111, 8'hD4, 8'hE5, 8'hF6);
        #1;
        rst = 1'b0;
        #1;
        check("rs_release_ready", 32'(rdy()), 32'b111);
        push_exp(8'hD4, 8'hE5, 8'hF6, 8'd0);
        tick(1);
        pop_check("rs_first_load");

        // Never-valid channels for 300 frames: counter saturates at 255.
        drive(3'b111, 3'b000, 8'h00, 8'h00, 8'h00);
        for (int f = 1; f <= 300; f++) begin
            span(23, saw);
            check($sformatf("sat%0d_gap", f), 32'(saw), 32'd0);
            tick(1);
            check($sformatf("sat%0d_frame_start", f), 32'(bus.frame_start), 32'd1);
            if (f == 84) check("sat_underrun_252", 32'(bus.underrun_cnt), 32'd252);
            if (f == 85) check("sat_underrun_255", 32'(bus.underrun_cnt), 32'd255);
        end
        check("sat_underrun_hold", 32'(bus.underrun_cnt), 32'd255);
        check("sat_channel1", 32'(bus.channel1), 32'h00);
        check("sat_channel2", 32'(bus.channel2), 32'h00);
        check("sat_channel3", 32'(bus.channel3), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
